// File: rtl/cdb_broadcaster_if.sv
// Bundle between the functional units and the CDB transmit end: per-FU result
// handshakes plus the registered broadcast that the ROB, RS and map table observe.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_broadcaster_if #(
    parameter int unsigned NUM_FU  = 4,
    parameter int unsigned TAG_LEN = `ROB_TAG_LEN,
    parameter int unsigned XLEN    = `XLEN
);
    typedef struct packed {
        logic               valid;
        logic [TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]    value;
    } cdb_data_t;

    logic [NUM_FU-1:0]               fu_valid;
    logic [NUM_FU-1:0][TAG_LEN-1:0]  fu_rob_tag;
    logic [NUM_FU-1:0][XLEN-1:0]     fu_value;
    logic [NUM_FU-1:0]               fu_ready;
    cdb_data_t                       cdb_data;

    modport master (
        output fu_valid, fu_rob_tag, fu_value,
        input  fu_ready, cdb_data
    );

    modport slave (
        input  fu_valid, fu_rob_tag, fu_value,
        output fu_ready, cdb_data
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: small per-FU result FIFOs, round-robin pick of one head per
// cycle, and a registered broadcast that is all-zero whenever nothing is sent.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_broadcaster #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic               clock,
    input logic               reset,
    input logic               flush,
    cdb_broadcaster_if.slave  bus
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned IdxW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned TagW  = `ROB_TAG_LEN;
    localparam int unsigned XlenW = `XLEN;

    logic [TagW-1:0]  tag_mem   [NUM_FU][FIFO_DEPTH];
    logic [XlenW-1:0] value_mem [NUM_FU][FIFO_DEPTH];
    logic [PtrW-1:0]  head_q    [NUM_FU];
    logic [PtrW-1:0]  tail_q    [NUM_FU];
    logic [CntW-1:0]  count_q   [NUM_FU];
    logic [IdxW-1:0]  rr_q;

    logic             cdb_valid_q;
    logic [TagW-1:0]  cdb_tag_q;
    logic [XlenW-1:0] cdb_value_q;

    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              win_valid;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   rr_next;
    logic              clear;

    // Flush and reset have the same effect on every piece of state.
    assign clear = !reset || flush;

    always_comb begin
        ready = '0;
        push  = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            ready[i] = (count_q[i] != CntW'(FIFO_DEPTH));
            push[i]  = bus.fu_valid[i] && ready[i];
        end
    end

    assign bus.fu_ready = ready;

    // First non-empty FIFO at or after rr_q, wrapping around.
    always_comb begin
        logic [IdxW-1:0] cidx;
        win_valid = 1'b0;
        win_idx   = '0;
        cidx      = '0;
        pop       = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cidx = IdxW'((32'(rr_q) + k) % NUM_FU);
            if (!win_valid && (count_q[cidx] != '0)) begin
                win_valid = 1'b1;
                win_idx   = cidx;
            end
        end
        if (win_valid) begin
            pop[win_idx] = 1'b1;
        end
        rr_next = IdxW'((32'(win_idx) + 1) % NUM_FU);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail_q[i] <= tail_q[i] + PtrW'(1);
                end
                if (pop[i]) begin
                    head_q[i] <= head_q[i] + PtrW'(1);
                end
                count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            end
            if (win_valid) begin
                rr_q        <= rr_next;
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= tag_mem[win_idx][head_q[win_idx]];
                cdb_value_q <= value_mem[win_idx][head_q[win_idx]];
            end else begin
                cdb_valid_q <= 1'b0;
                cdb_tag_q   <= '0;
                cdb_value_q <= '0;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tag_mem[i][tail_q[i]]   <= bus.fu_rob_tag[i];
                    value_mem[i][tail_q[i]] <= bus.fu_value[i];
                end
            end
        end
    end

    assign bus.cdb_data = {cdb_valid_q, cdb_tag_q, cdb_value_q};
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: per-FU result queues drive the handshake,
// a monitor logs every broadcast, and each test compares the log to hand-derived order.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_broadcaster;
    localparam int NF = 4;
    localparam int TW = `ROB_TAG_LEN;
    localparam int XW = `XLEN;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    cdb_broadcaster_if #(.NUM_FU(NF), .TAG_LEN(TW), .XLEN(XW)) bus ();

    cdb_broadcaster #(.NUM_FU(NF), .FIFO_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [TW+XW-1:0] pend [NF][$];
    logic [TW-1:0]    log_tag [$];
    logic [XW-1:0]    log_val [$];
    int               log_cyc [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [XW-1:0] mkval(input int t);
        return 32'hC0DE_0000 | XW'(t);
    endfunction

    function automatic logic [63:0] tag_at(input int j);
        return (j < log_tag.size()) ? 64'(log_tag[j]) : 64'hFFFF;
    endfunction

    function automatic logic [63:0] val_at(input int j);
        return (j < log_val.size()) ? 64'(log_val[j]) : 64'hFFFF_FFFF_FFFF;
    endfunction

    function automatic int cyc_at(input int j);
        return (j < log_cyc.size()) ? log_cyc[j] : -1000;
    endfunction

    task automatic add(input int fu, input int tag, input logic [XW-1:0] v);
        pend[fu].push_back({TW'(tag), v});
    endtask

    task automatic clear_pend();
        for (int i = 0; i < NF; i++) pend[i].delete();
    endtask

    task automatic clear_log();
        log_tag.delete();
        log_val.delete();
        log_cyc.delete();
    endtask

    // An FU only raises valid when it sees ready, so it never violates the handshake.
    task automatic drive();
        for (int i = 0; i < NF; i++) begin
            if (pend[i].size() != 0 && bus.fu_ready[i] === 1'b1) begin
                bus.fu_valid[i] = 1'b1;
                {bus.fu_rob_tag[i], bus.fu_value[i]} = pend[i][0];
            end else begin
                bus.fu_valid[i]   = 1'b0;
                bus.fu_rob_tag[i] = '0;
                bus.fu_value[i]   = '0;
            end
        end
    endtask

    task automatic step();
        logic [NF-1:0] acc;
        acc = bus.fu_valid & bus.fu_ready;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NF; i++) begin
            if (acc[i] === 1'b1) void'(pend[i].pop_front());
        end
        if (bus.cdb_data.valid === 1'b1) begin
            log_tag.push_back(bus.cdb_data.rob_tag);
            log_val.push_back(bus.cdb_data.value);
            log_cyc.push_back(cyc);
        end else if (reset === 1'b1) begin
            check("idle_zero", {bus.cdb_data.rob_tag, bus.cdb_data.value}, '0);
        end
        drive();
    endtask

    task automatic expect_seq(input string name, input int exp_tags[], input bit chk_val);
        check({name, "_count"}, log_tag.size(), exp_tags.size());
        for (int j = 0; j < exp_tags.size(); j++) begin
            check({name, "_tag"}, tag_at(j), exp_tags[j]);
            if (chk_val) check({name, "_val"}, val_at(j), mkval(exp_tags[j]));
        end
        if (exp_tags.size() > 1)
            check({name, "_back2back"}, cyc_at(exp_tags.size() - 1) - cyc_at(0),
                  exp_tags.size() - 1);
    endtask

    initial begin
        int  seq[];
        bit  saw_stall;

        bus.fu_valid   = '0;
        bus.fu_rob_tag = '0;
        bus.fu_value   = '0;

        // Reset
        reset = 1'b0;
        step();
        step();
        check("rst_valid", bus.cdb_data.valid, 1'b0);
        check("rst_tag_value", {bus.cdb_data.rob_tag, bus.cdb_data.value}, '0);
        check("rst_ready", bus.fu_ready, 4'hF);
        reset = 1'b1;
        step();
        step();

        // Single result: accepted at the end of cycle 5, visible only in cycle 7
        clear_log();
        add(2, 3, 32'hDEAD_BEEF);
        drive();
        step();
        check("single_c6_valid", bus.cdb_data.valid, 1'b0);
        step();
        check("single_c7_valid", bus.cdb_data.valid, 1'b1);
        check("single_c7_tag", bus.cdb_data.rob_tag, 3);
        check("single_c7_value", bus.cdb_data.value, 32'hDEAD_BEEF);
        step();
        check("single_c8_valid", bus.cdb_data.valid, 1'b0);

        // Collision from rr_ptr = 0, then FU0 beats FU3 once the pointer wraps
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_pend();
        clear_log();
        add(0, 1, mkval(1));
        add(1, 2, mkval(2));
        add(3, 3, mkval(3));
        drive();
        repeat (5) step();
        seq = '{1, 2, 3};
        expect_seq("collide", seq, 1'b1);
        clear_log();
        add(0, 4, mkval(4));
        add(3, 5, mkval(5));
        drive();
        repeat (4) step();
        seq = '{4, 5};
        expect_seq("rr_wrap", seq, 1'b1);

        // Backpressure: FU1 stalls on a full FIFO while FU0 keeps competing
        clear_log();
        for (int k = 0; k < 4; k++) begin
            add(0, 20 + k, mkval(20 + k));
            add(1, 10 + k, mkval(10 + k));
        end
        drive();
        saw_stall = 1'b0;
        repeat (12) begin
            step();
            if (bus.fu_ready[1] === 1'b0) saw_stall = 1'b1;
        end
        check("bp_ready_dropped", saw_stall, 1'b1);
        check("bp_all_accepted", pend[1].size(), 0);
        seq = '{20, 10, 21, 11, 22, 12, 23, 13};
        expect_seq("bp", seq, 1'b1);

        // Saturation: every FU always has work; strict FU0..FU3 rotation
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_pend();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < 12; k++) add(f, f * 16 + k, mkval(f * 16 + k));
        drive();
        clear_log();
        repeat (45) step();
        for (int j = 0; j < 40; j++) begin
            check("sat_tag", tag_at(j), (j % 4) * 16 + j / 4);
            check("sat_val", val_at(j), mkval((j % 4) * 16 + j / 4));
        end
        check("sat_back2back", cyc_at(39) - cyc_at(0), 39);

        // Flush mid-stream with FU2 pushing in the flush cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_pend();
        drive();
        clear_log();
        for (int k = 0; k < 3; k++) begin
            add(0, 30 + k, mkval(30 + k));
            add(1, 40 + k, mkval(40 + k));
            add(3, 50 + k, mkval(50 + k));
        end
        drive();
        repeat (3) step();
        flush = 1'b1;
        add(2, 60, mkval(60));
        drive();
        step();
        check("flush_valid", bus.cdb_data.valid, 1'b0);
        check("flush_ready", bus.fu_ready, 4'hF);
        flush = 1'b0;
        clear_pend();
        drive();
        repeat (6) step();
        seq = '{30, 40};
        expect_seq("flush", seq, 1'b1);

        // Reset mid-operation while rr_ptr sits at 1
        clear_log();
        for (int k = 0; k < 3; k++) begin
            add(0, 1 + k, mkval(1 + k));
            add(1, 11 + k, mkval(11 + k));
            add(3, 21 + k, mkval(21 + k));
        end
        drive();
        repeat (2) step();
        reset = 1'b0;
        flush = 1'b1;
        add(2, 61, mkval(61));
        drive();
        step();
        check("rstop_valid", bus.cdb_data.valid, 1'b0);
        check("rstop_tag_value", {bus.cdb_data.rob_tag, bus.cdb_data.value}, '0);
        check("rstop_ready", bus.fu_ready, 4'hF);
        reset = 1'b1;
        flush = 1'b0;
        clear_pend();
        drive();
        repeat (4) step();
        seq = '{1};
        expect_seq("rstop_pre", seq, 1'b1);
        clear_log();
        for (int f = 0; f < NF; f++) add(f, 4 + f, mkval(4 + f));
        drive();
        repeat (8) step();
        seq = '{4, 5, 6, 7};
        expect_seq("rstop_rr0", seq, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
